// File: rtl/vfpu_result_buffer_pkg.sv
// Shared types for the vfpu result buffer: FP word, flag bundle and buffered entry layout.
package vfpu_result_buffer_pkg;

  localparam int unsigned VFPU_RESBUF_DEPTH = 4;

  typedef logic [31:0] fp_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } flags_vfpu_t;

  typedef struct packed {
    fp_t         result;
    flags_vfpu_t flags;
  } vfpu_resbuf_entry_t;

endpackage

// File: rtl/vfpu_credit_ctr.sv
// In-flight operation counter; grants a credit only while a buffer slot is still unreserved.
module vfpu_credit_ctr #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             issue_i,
  input  logic             done_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [CNT_W-1:0] inflight_o,
  output logic             issue_ready_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [SUM_W-1:0] credSum;
  logic             issueAcc;

  // Reserved slots are stored entries plus results still inside vfpu.
  assign credSum       = {1'b0, count_i} + {1'b0, inflight_q};
  assign issue_ready_o = credSum < SUM_W'(DEPTH);
  assign issueAcc      = issue_i & issue_ready_o;
  assign inflight_o    = inflight_q;

  always_comb begin
    inflight_d = inflight_q;
    if (issueAcc && !done_i && inflight_q != CNT_W'(DEPTH)) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issueAcc && done_i && inflight_q != '0) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else if (clear_i) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: rtl/vfpu_result_buffer.sv
// Result FIFO behind vfpu: captures results on done, streams them out on valid/ready,
// and feeds back issue credits since vfpu itself cannot be stalled.
module vfpu_result_buffer
  import vfpu_result_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = VFPU_RESBUF_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             issue_i,
  output logic             issue_ready_o,
  input  fp_t              result_i,
  input  flags_vfpu_t      flags_i,
  input  logic             done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output fp_t              out_data_o,
  output flags_vfpu_t      out_flags_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] inflight_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  vfpu_resbuf_entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] inflight;
  logic             doneErr, pushEn, popEn, outValid;

  assign outValid = count_q != '0;
  // A done with no matching credit, or into a full FIFO, is dropped and flagged.
  assign doneErr  = done_i & ~clear_i & ((inflight == '0) | (count_q == CNT_W'(DEPTH)));
  assign pushEn   = done_i & ~clear_i & ~doneErr;
  assign popEn    = outValid & out_ready_i & ~clear_i;

  vfpu_credit_ctr #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_credit (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .issue_i       (issue_i),
    .done_i        (pushEn),
    .count_i       (count_q),
    .inflight_o    (inflight),
    .issue_ready_o (issue_ready_o)
  );

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q | doneErr;
    if (pushEn) begin
      wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (popEn) begin
      rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
    end
    if (pushEn && !popEn) begin
      count_d = count_q + CNT_W'(1);
    end else if (!pushEn && popEn) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is visible.
  always_ff @(posedge clk_i) begin
    if (rst_ni && pushEn) begin
      mem_q[wrPtr_q] <= '{result: result_i, flags: flags_i};
    end
  end

  assign out_valid_o = outValid;
  assign out_data_o  = outValid ? mem_q[rdPtr_q].result : '0;
  assign out_flags_o = outValid ? mem_q[rdPtr_q].flags : '0;
  assign count_o     = count_q;
  assign inflight_o  = inflight;
  assign overflow_o  = overflow_q;

endmodule
